// File: rtl/memory_nrw_wb_pkg.sv
// Shared constants and types for the multi-port Wishbone RAM and its response pipelines.
package memory_nrw_wb_pkg;

    localparam int MAX_PORTS = 4;
    localparam int PTR_W     = 2;

    localparam logic [7:0] BYTE_LANE_MASK = 8'hFF;

    typedef enum logic {
        LAT1 = 1'b0,
        LAT2 = 1'b1
    } lat_e;

    typedef enum logic [1:0] {
        RESP_RD  = 2'd0,
        RESP_WR  = 2'd1,
        RESP_ERR = 2'd2
    } resp_e;

endpackage

// File: rtl/memory_port_resp.sv
// Per-port response pipeline: delays ack/err by the configured latency and holds read data.
module memory_port_resp
    import memory_nrw_wb_pkg::*;
#(
    parameter int   DATA_WIDTH = 32,
    parameter lat_e LAT        = LAT1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  vld_i,
    input  resp_e                 kind_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] dat_o
);

    logic                  s1_vld_q, s1_vld_d;
    resp_e                 s1_kind_q, s1_kind_d;
    logic [DATA_WIDTH-1:0] s1_dat_q, s1_dat_d;
    logic                  out_vld_d;
    resp_e                 out_kind_d;
    logic [DATA_WIDTH-1:0] out_dat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    // Writes skip the extra stage when it is empty so they ack after one cycle without reordering.
    always_comb begin
        s1_vld_d   = 1'b0;
        s1_kind_d  = s1_kind_q;
        s1_dat_d   = s1_dat_q;
        out_vld_d  = 1'b0;
        out_kind_d = kind_i;
        out_dat_d  = dat_i;
        if (LAT == LAT1) begin
            out_vld_d = vld_i;
        end else if (s1_vld_q) begin
            out_vld_d  = 1'b1;
            out_kind_d = s1_kind_q;
            out_dat_d  = s1_dat_q;
            s1_vld_d   = vld_i;
            s1_kind_d  = kind_i;
            s1_dat_d   = dat_i;
        end else if (vld_i && kind_i == RESP_WR) begin
            out_vld_d = 1'b1;
        end else begin
            s1_vld_d  = vld_i;
            s1_kind_d = kind_i;
            s1_dat_d  = dat_i;
        end
        if (!cyc_i) begin
            s1_vld_d  = 1'b0;
            out_vld_d = 1'b0;
        end
        ack_d = out_vld_d && (out_kind_d != RESP_ERR);
        err_d = out_vld_d && (out_kind_d == RESP_ERR);
        dat_d = (out_vld_d && out_kind_d == RESP_RD) ? out_dat_d : dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        s1_kind_q <= s1_kind_d;
        s1_dat_q  <= s1_dat_d;
    end

    // A master that drops cyc no longer wants the response already in flight.
    assign ack_o = ack_q & cyc_i;
    assign err_o = err_q & cyc_i;
    assign dat_o = dat_q;

endmodule

// File: rtl/memory_nrw_wb.sv
// Multi-port pipelined Wishbone RAM with round-robin resolution of same-word write conflicts.
module memory_nrw_wb
    import memory_nrw_wb_pkg::*;
#(
    parameter int  NUM_PORTS    = 2,
    parameter int  DATA_WIDTH   = 32,
    parameter int  ADDR_WIDTH   = 9,
    parameter int  READ_LATENCY = 1,
    localparam int NUM_WMASKS   = DATA_WIDTH / 8
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic [NUM_PORTS-1:0]             port_wb_cyc_i,
    input  logic [NUM_PORTS-1:0]             port_wb_stb_i,
    input  logic [NUM_PORTS-1:0]             port_wb_we_i,
    input  logic [NUM_PORTS*32-1:0]          port_wb_adr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wb_dat_i,
    input  logic [NUM_PORTS*NUM_WMASKS-1:0]  port_wb_sel_i,
    output logic [NUM_PORTS-1:0]             port_wb_stall_o,
    output logic [NUM_PORTS-1:0]             port_wb_ack_o,
    output logic [NUM_PORTS-1:0]             port_wb_err_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wb_dat_o
);

    localparam int   RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int   HI_W      = 30 - ADDR_WIDTH;
    localparam lat_e LAT       = (READ_LATENCY == 2) ? LAT2 : LAT1;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [ADDR_WIDTH-1:0] widx  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wmask [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rdata [NUM_PORTS];
    resp_e                 kind  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  req, in_rng, wr, conf, lose, acc;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [2*NUM_PORTS-1:0] unused_adr_lsbs;

    function automatic int prio(input int x, input logic [PTR_W-1:0] rr);
        return (x + NUM_PORTS - int'(rr)) % NUM_PORTS;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            widx[p]   = port_wb_adr_i[32*p+2 +: ADDR_WIDTH];
            in_rng[p] = (port_wb_adr_i[32*p+ADDR_WIDTH+2 +: HI_W] == '0);
            unused_adr_lsbs[2*p +: 2] = port_wb_adr_i[32*p +: 2];
            req[p]    = port_wb_cyc_i[p] & port_wb_stb_i[p] & ~wb_rst_i;
            wr[p]     = req[p] & port_wb_we_i[p] & in_rng[p];
            kind[p]   = !in_rng[p] ? RESP_ERR : (port_wb_we_i[p] ? RESP_WR : RESP_RD);
            rdata[p]  = mem[widx[p]];
            wmask[p]  = '0;
            for (int b = 0; b < NUM_WMASKS; b++) begin
                wmask[p][8*b +: 8] = port_wb_sel_i[NUM_WMASKS*p+b] ? BYTE_LANE_MASK : 8'h00;
            end
        end
    end

    // Only writers to the same word compete; the port nearest the pointer wins.
    always_comb begin
        conf = '0;
        lose = '0;
        rr_d = rr_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q != p && wr[p] && wr[q] && widx[p] == widx[q]) begin
                    conf[p] = 1'b1;
                    if (prio(q, rr_q) < prio(p, rr_q)) lose[p] = 1'b1;
                end
            end
        end
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (conf[p] && !lose[p]) rr_d = PTR_W'((p + 1) % NUM_PORTS);
        end
        acc = req & ~lose;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) rr_q <= '0;
        else          rr_q <= rr_d;
    end

    always_ff @(posedge wb_clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (acc[p] && wr[p]) begin
                mem[widx[p]] <= (mem[widx[p]] & ~wmask[p])
                              | (port_wb_dat_i[DATA_WIDTH*p +: DATA_WIDTH] & wmask[p]);
            end
        end
    end

    assign port_wb_stall_o = lose;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        memory_port_resp #(
            .DATA_WIDTH (DATA_WIDTH),
            .LAT        (LAT)
        ) u_resp (
            .clk_i  (wb_clk_i),
            .rst_i  (wb_rst_i),
            .cyc_i  (port_wb_cyc_i[p]),
            .vld_i  (acc[p]),
            .kind_i (kind[p]),
            .dat_i  (rdata[p]),
            .ack_o  (port_wb_ack_o[p]),
            .err_o  (port_wb_err_o[p]),
            .dat_o  (port_wb_dat_o[DATA_WIDTH*p +: DATA_WIDTH])
        );
    end

endmodule
